dds_mix_fir_chain: RTL

- Parametrised successor of the two-DDS / mixer / FIR chain.
- Two phase-accumulator DDS channels with runtime tuning words and a channel-2 phase offset, a saturating signed mixer, and a TAPS-deep direct-form FIR with a runtime-writable coefficient bank.
- Adds pipeline enable, phase clear and an output-valid flag.
- Sits between the DDS stimulus and the downstream sample consumer; widths and depth are set per instance.

---
 rtl/dds_fir_pkg.sv | 34 +++
 rtl/sine_lut.sv | 35 +++
 rtl/dds_mix_fir_chain.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dds_fir_pkg.sv
// Shared helpers for the DDS / mixer / FIR chain: width derivation, saturation
// and the coefficient bank reset value.
package dds_fir_pkg;

   localparam int SAT_W = 64;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + clog2(taps);
   endfunction

   // Largest positive Q1.(coef_w-1) value, loaded into coef[0] for near-passthrough
   function automatic int coef_reset(input int coef_w);
      return (1 << (coef_w - 1)) - 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                   input int width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      else if (value < lo) return lo;
      else return value;
   endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered sine ROM: one read port, output updates only when en is high.
module sine_lut #(
   parameter int LUT_AW = 8,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [LUT_AW-1:0]        addr,
   output logic signed [DATA_W-1:0] data
);

   localparam int DEPTH = 1 << LUT_AW;

   // Full-scale sine, rounded half away from zero, evaluated at elaboration
   function automatic logic signed [DATA_W-1:0] sin_entry(input int i);
      real amp;
      real v;
      amp = real'((1 << (DATA_W - 1)) - 1);
      v   = amp * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(DEPTH));
      return DATA_W'($rtoi((v >= 0.0) ? (v + 0.5) : (v - 0.5)));
   endfunction

   logic signed [DATA_W-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = sin_entry(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else if (en) data <= rom[addr];
   end

endmodule

// File: rtl/dds_mix_fir_chain.sv
// Two DDS channels -> saturating mixer -> TAPS-deep direct-form FIR with a
// runtime-writable coefficient bank and a pipeline-primed flag.
module dds_mix_fir_chain
   import dds_fir_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 8,
   parameter int TAPS    = 8,
   parameter int COEF_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       ftw_load,
   input  logic [PHASE_W-1:0]         ftw1,
   input  logic [PHASE_W-1:0]         ftw2,
   input  logic [PHASE_W-1:0]         poff2,
   input  logic                       phase_clr,
   input  logic                       coef_we,
   input  logic [clog2(TAPS)-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic signed [DATA_W-1:0]   out_dds1,
   output logic signed [DATA_W-1:0]   out_dds2,
   output logic signed [DATA_W-1:0]   multiplied,
   output logic signed [DATA_W-1:0]   out_fir,
   output logic                       out_valid
);

   localparam int ACC_W    = acc_width(DATA_W, COEF_W, TAPS);
   localparam int TERM_W   = DATA_W + COEF_W;
   localparam int PROD_W   = 2 * DATA_W;
   localparam int VLD_N    = TAPS + 3;
   localparam int CNT_W    = clog2(VLD_N + 1);
   localparam int COEF_RST = coef_reset(COEF_W);

   logic [PHASE_W-1:0]       ftw1_r;
   logic [PHASE_W-1:0]       ftw2_r;
   logic [PHASE_W-1:0]       poff2_r;
   logic [PHASE_W-1:0]       ph1_p0;
   logic [PHASE_W-1:0]       ph2_p0;
   logic [CNT_W-1:0]         vld_cnt;
   logic [LUT_AW-1:0]        addr1_p0;
   logic [LUT_AW-1:0]        addr2_p0;
   logic signed [PROD_W-1:0] prod_p1;
   logic signed [PROD_W-1:0] prod_sh_p1;
   logic signed [COEF_W-1:0] coef [TAPS];
   logic signed [DATA_W-1:0] hist_p2 [TAPS-1];
   logic signed [ACC_W-1:0]  acc_p2;
   logic signed [ACC_W-1:0]  acc_sh_p2;
   logic signed [TERM_W-1:0] term_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ftw1_r  <= '0;
         ftw2_r  <= '0;
         poff2_r <= '0;
      end else if (ftw_load) begin
         ftw1_r  <= ftw1;
         ftw2_r  <= ftw2;
         poff2_r <= poff2;
      end
   end

   // Stage 0: phase accumulators and the priming counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph1_p0  <= '0;
         ph2_p0  <= '0;
         vld_cnt <= '0;
      end else if (phase_clr) begin
         ph1_p0  <= '0;
         ph2_p0  <= '0;
         vld_cnt <= '0;
      end else if (en) begin
         ph1_p0 <= ph1_p0 + ftw1_r;
         ph2_p0 <= ph2_p0 + ftw2_r;
         if (vld_cnt != CNT_W'(VLD_N)) vld_cnt <= vld_cnt + CNT_W'(1);
      end
   end

   assign out_valid = (vld_cnt == CNT_W'(VLD_N));
   assign addr1_p0  = LUT_AW'(ph1_p0 >> (PHASE_W - LUT_AW));
   assign addr2_p0  = LUT_AW'((ph2_p0 + poff2_r) >> (PHASE_W - LUT_AW));

   // Stage 1: sine lookup
   sine_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .addr  (addr1_p0),
      .data  (out_dds1)
   );

   sine_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .addr  (addr2_p0),
      .data  (out_dds2)
   );

   // Stage 2: mixer, full-width product scaled back by floor shift
   assign prod_p1    = PROD_W'(out_dds1) * PROD_W'(out_dds2);
   assign prod_sh_p1 = prod_p1 >>> (DATA_W - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) multiplied <= '0;
      else if (en) multiplied <= DATA_W'(sat(SAT_W'(prod_sh_p1), DATA_W));
   end

   // Coefficient bank is written regardless of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) coef[k] <= '0;
         coef[0] <= COEF_W'(COEF_RST);
      end else if (coef_we && (int'(coef_addr) < TAPS)) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // The mixer register is tap 0; hist_p2[j] holds tap j+1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < TAPS - 1; j++) hist_p2[j] <= '0;
      end else if (en) begin
         hist_p2[0] <= multiplied;
         for (int j = 1; j < TAPS - 1; j++) hist_p2[j] <= hist_p2[j-1];
      end
   end

   always_comb begin
      term_p2 = TERM_W'(coef[0]) * TERM_W'(multiplied);
      acc_p2  = ACC_W'(term_p2);
      for (int k = 1; k < TAPS; k++) begin
         term_p2 = TERM_W'(coef[k]) * TERM_W'(hist_p2[k-1]);
         acc_p2  = acc_p2 + ACC_W'(term_p2);
      end
   end

   assign acc_sh_p2 = acc_p2 >>> (COEF_W - 1);

   // Stage 3: filter output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_fir <= '0;
      else if (en) out_fir <= DATA_W'(sat(SAT_W'(acc_sh_p2), DATA_W));
   end

endmodule
